// File: rtl/instruction_encoder.sv
// RV32I field-bundle to instruction-word encoder with a 2-entry output FIFO and
// sequential byte-address tagging. Optional immediate range check: ENCODER_IMM_CHECK_EN.
module instruction_encoder #(
   parameter int               ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [2:0]        in_funct3,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   input  logic              addr_clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_illegal
`ifdef ENCODER_IMM_CHECK_EN
   ,output logic             out_imm_err
`endif
);

   logic [31:0]       enc_instr;
   logic              enc_illegal;
   logic [1:0][31:0]  mem_instr;
   logic [1:0]        mem_illegal;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic [ADDR_W-1:0] addr;
   logic              push;
   logic              pop;

   always_comb begin
      enc_instr   = 32'h0000_0013;
      enc_illegal = 1'b0;
      case (in_fmt)
         3'd0: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         3'd1: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         3'd2: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         3'd3: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
         3'd4: enc_instr = {in_imm[31:12], in_rd, in_opcode};
         3'd5: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
         default: enc_illegal = 1'b1;
      endcase
   end

`ifdef ENCODER_IMM_CHECK_EN
   logic              enc_imm_err;
   logic [1:0]        mem_imm_err;
   logic signed [31:0] imm_s;

   assign imm_s = $signed(in_imm);

   always_comb begin
      enc_imm_err = 1'b0;
      case (in_fmt)
         3'd1, 3'd2: enc_imm_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         3'd3: enc_imm_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
         3'd4: enc_imm_err = |in_imm[11:0];
         3'd5: enc_imm_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
         default: enc_imm_err = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_imm_err <= '0;
      end else if (push) begin
         mem_imm_err[wr_ptr] <= enc_imm_err;
      end
   end

   assign out_imm_err = mem_imm_err[rd_ptr];
`endif

   // Ready comes from the registered count only, so a full buffer refuses a push
   // even when the head is being popped in the same cycle.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_instr   <= '0;
         mem_illegal <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push) begin
            mem_instr[wr_ptr]   <= enc_instr;
            mem_illegal[wr_ptr] <= enc_illegal;
            wr_ptr              <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= BASE_ADDR;
      end else if (addr_clear) begin
         addr <= BASE_ADDR;
      end else if (pop) begin
         addr <= addr + ADDR_W'(4);
      end
   end

   assign out_instr   = mem_instr[rd_ptr];
   assign out_illegal = mem_illegal[rd_ptr];
   assign out_addr    = addr;

endmodule
